// File: rtl/hpdl_pkg.sv
// hpdl_pkg: shared FSM states, default timing, display geometry and blank code for the HPDL refresher
package hpdl_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SETUP, STROBE, HOLD, NEXT, GAP} state_t;
  localparam int DEF_SETUP = 2;
  localparam int DEF_STROBE = 4;
  localparam int DEF_HOLD = 2;
  localparam int DEF_GAP = 1000;
  localparam int N_DISP = 4;
  localparam int N_DIGIT = 4;
  localparam logic [6:0] BLANK = 7'h20;
  function automatic int at_least_1(input int v);
    return v < 1 ? 1 : v;
  endfunction
endpackage

// File: rtl/hpdl_char_map.sv
// hpdl_char_map: folds a buffer byte into the HPDL 7-bit set (raw 8-bit in, glyph 7-bit out; lowercase to upper, unprintables to space)
module hpdl_char_map
  import hpdl_pkg::*;
(
  input  logic [7:0] raw,
  output logic [6:0] glyph
);
  always_comb glyph = (raw >= 8'h20 && raw <= 8'h5F) ? raw[6:0] :
                      (raw >= 8'h61 && raw <= 8'h7A) ? raw[6:0] - 7'h20 : BLANK;
endmodule

// File: rtl/hpdl_refresh.sv
// hpdl_refresh: scans a 16-char buffer onto four 4-digit HPDL displays (i_clk/i_rst_n/i_enable in, buffer read port, o_data/o_addr/o_wr_n bus, o_frame_done pulse)
module hpdl_refresh
  import hpdl_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP,
  parameter int STROBE_CYCLES = DEF_STROBE,
  parameter int HOLD_CYCLES   = DEF_HOLD,
  parameter int GAP_CYCLES    = DEF_GAP
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic              o_read_enable,
  output logic [3:0]        o_read_address,
  input  logic [7:0]        i_read_data,
  output logic [6:0]        o_data,
  output logic [1:0]        o_addr,
  output logic [N_DISP-1:0] o_wr_n,
  output logic              o_frame_done
);
  localparam int SU = at_least_1(SETUP_CYCLES);
  localparam int SB = at_least_1(STROBE_CYCLES);
  localparam int HO = at_least_1(HOLD_CYCLES);
  localparam int GA = at_least_1(GAP_CYCLES);
  localparam int M1 = SU > SB ? SU : SB;
  localparam int M2 = HO > GA ? HO : GA;
  localparam int MX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MX) < 1 ? 1 : $clog2(MX);
  localparam logic [3:0] LAST = 4'(N_DISP * N_DIGIT - 1);
  state_t st;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic [6:0] ch;
  logic done;
  hpdl_char_map u_map (.raw(i_read_data), .glyph(ch));
  always_comb done = cnt == '0;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st <= IDLE;
      idx <= '0;
      cnt <= '0;
      o_read_enable <= 1'b0;
      o_read_address <= '0;
      o_data <= BLANK;
      o_addr <= '0;
      o_wr_n <= '1;
      o_frame_done <= 1'b0;
    end else begin
      o_read_enable <= 1'b0;
      o_frame_done <= 1'b0;
      case (st)
        IDLE: if (i_enable) begin
          st <= FETCH;
          idx <= '0;
          o_read_enable <= 1'b1;
          o_read_address <= '0;
        end
        FETCH: st <= LATCH;
        LATCH: begin
          o_data <= ch;
          o_addr <= 2'd3 - idx[1:0];
          cnt <= CW'(SU - 1);
          st <= SETUP;
        end
        SETUP: if (done) begin
          o_wr_n <= ~(4'b0001 << idx[3:2]);
          cnt <= CW'(SB - 1);
          st <= STROBE;
        end else cnt <= cnt - 1'b1;
        STROBE: if (done) begin
          o_wr_n <= '1;
          cnt <= CW'(HO - 1);
          st <= HOLD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (done) st <= NEXT;
        else cnt <= cnt - 1'b1;
        NEXT: if (!i_enable) st <= IDLE;
        else if (idx == LAST) begin
          o_frame_done <= 1'b1;
          idx <= '0;
          cnt <= CW'(GA - 1);
          st <= GAP;
        end else begin
          idx <= idx + 1'b1;
          o_read_enable <= 1'b1;
          o_read_address <= idx + 1'b1;
          st <= FETCH;
        end
        GAP: if (!done) cnt <= cnt - 1'b1;
        else if (i_enable) begin
          st <= FETCH;
          o_read_enable <= 1'b1;
          o_read_address <= idx;
        end else st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hpdl_refresh.sv
// tb_hpdl_refresh: scoreboard bench for hpdl_refresh with a buffer model and a protocol monitor
module tb_hpdl_refresh;
  localparam int SETUP = 2, STROBE = 4, HOLD = 2, GAP = 10;
  logic i_clk = 0, i_rst_n = 0, i_enable = 0;
  logic o_read_enable;
  logic [3:0] o_read_address;
  logic [7:0] i_read_data = 0;
  logic [6:0] o_data;
  logic [1:0] o_addr;
  logic [3:0] o_wr_n;
  logic o_frame_done;
  hpdl_refresh #(.SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .o_read_enable(o_read_enable), .o_read_address(o_read_address), .i_read_data(i_read_data),
    .o_data(o_data), .o_addr(o_addr), .o_wr_n(o_wr_n), .o_frame_done(o_frame_done));
  always #5 i_clk = ~i_clk;
  typedef struct { int pos; int disp; logic [1:0] addr; logic [6:0] data; } wr_t;
  wr_t exp_q[$];
  logic [7:0] mem [16];
  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0;
  int fd_at[$];
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_read_enable) i_read_data <= mem[o_read_address];
  end
  function automatic logic [6:0] ref_map(input logic [7:0] c);
    if (c >= 32 && c <= 95) return c[6:0];
    if (c >= 97 && c <= 122) return 7'(c - 32);
    return 7'h20;
  endfunction
  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  task automatic push(input int a, input int b);
    for (int p = a; p <= b; p++) begin
      wr_t e;
      e.pos = p;
      e.disp = p / 4;
      e.addr = 2'(3 - p % 4);
      e.data = ref_map(mem[p]);
      exp_q.push_back(e);
    end
  endtask
  task automatic wait_fd(input int n);
    int k = 0;
    while (fd_cnt < n && k < 400) begin
      @(negedge i_clk);
      k++;
    end
    chk(fd_cnt >= n, "frame_done_timeout", fd_cnt, n);
  endtask
  task automatic wait_wr(input logic [3:0] w, input logic [1:0] a);
    int k = 0;
    while (!(o_wr_n == w && o_addr == a) && k < 400) begin
      @(negedge i_clk);
      k++;
    end
    chk(o_wr_n == w && o_addr == a, "strobe_timeout", int'(o_wr_n), int'(w));
  endtask
  task automatic chk_reset();
    chk(o_wr_n == 4'hF, "rst_wr_n", o_wr_n, 15);
    chk(o_read_enable == 0, "rst_read_enable", o_read_enable, 0);
    chk(o_read_address == 0, "rst_read_address", o_read_address, 0);
    chk(o_data == 7'h20, "rst_data", o_data, 32);
    chk(o_addr == 0, "rst_addr", o_addr, 0);
    chk(o_frame_done == 0, "rst_frame_done", o_frame_done, 0);
  endtask
  task automatic rand_mem();
    for (int p = 0; p < 16; p++) mem[p] = 8'($urandom);
  endtask
  task automatic one_frame();
    int n = fd_cnt + 1;
    push(0, 15);
    i_enable = 1;
    wait_fd(n);
    i_enable = 0;
    repeat (20) @(negedge i_clk);
    chk(exp_q.size() == 0, "frame_queue_empty", exp_q.size(), 0);
    chk(fd_cnt == n, "frame_done_count", fd_cnt, n);
  endtask
  initial begin
    logic [3:0] pw = 4'hF;
    logic [8:0] pda = 0, fda = 0, cur;
    int stab = 0, lowc = 0, h = 0;
    bit hp = 0, pfd = 0, pre = 0;
    wr_t e;
    forever begin
      @(negedge i_clk);
      cur = {o_addr, o_data};
      if (!i_rst_n) begin
        pw = 4'hF; hp = 0; lowc = 0; pfd = 0; pre = 0; stab = 0; pda = cur;
        continue;
      end
      stab = (cur == pda) ? stab + 1 : 1;
      if (hp) begin
        if (cur != pda) begin
          hp = 0;
          chk(h >= HOLD, "hold_after_rise", h, HOLD);
        end else h++;
      end
      if (o_read_enable) begin
        chk(!pre, "read_enable_width", 2, 1);
        if (exp_q.size() == 0) chk(0, "read_unexpected", o_read_address, -1);
        else chk(int'(o_read_address) == exp_q[0].pos, "read_addr", o_read_address, exp_q[0].pos);
      end
      pre = o_read_enable;
      if (o_wr_n != 4'hF && pw == 4'hF) begin
        if (exp_q.size() == 0) chk(0, "strobe_unexpected", o_wr_n, 15);
        else begin
          e = exp_q.pop_front();
          chk(o_wr_n == ~(4'b0001 << e.disp), "strobe_display", o_wr_n, int'(~(4'b0001 << e.disp)));
          chk(o_addr == e.addr, "digit_addr", o_addr, e.addr);
          chk(o_data == e.data, "char_data", o_data, e.data);
          chk(stab >= SETUP + 1, "setup_before_fall", stab - 1, SETUP);
        end
        fda = cur;
        lowc = 1;
      end else if (o_wr_n != 4'hF) begin
        lowc++;
        chk(cur == fda, "stable_while_low", cur, fda);
      end
      if (o_wr_n != 4'hF) chk($countones(~o_wr_n) == 1, "one_strobe_low", o_wr_n, 0);
      if (o_wr_n == 4'hF && pw != 4'hF) begin
        chk(lowc == STROBE, "strobe_width", lowc, STROBE);
        hp = 1;
        h = 1;
      end
      if (o_frame_done) begin
        fd_cnt++;
        fd_at.push_back(cyc);
        chk(!pfd, "frame_done_width", 2, 1);
      end
      pfd = o_frame_done;
      pw = o_wr_n;
      pda = cur;
    end
  end
  initial begin
    logic [127:0] s = "HELLO WORLD 1234";
    int n, t1, t2;
    repeat (3) @(negedge i_clk);
    chk_reset();
    i_rst_n = 1;
    repeat (3) @(negedge i_clk);
    for (int p = 0; p < 16; p++) mem[p] = s[8*(15-p) +: 8];
    one_frame();
    rand_mem();
    mem[5] = 8'h61;
    mem[6] = 8'h7F;
    one_frame();
    rand_mem();
    push(0, 15);
    push(0, 15);
    n = fd_cnt;
    i_enable = 1;
    wait_fd(n + 1);
    wait_fd(n + 2);
    i_enable = 0;
    t1 = fd_at[fd_at.size()-2];
    t2 = fd_at[fd_at.size()-1];
    chk(t2 - t1 == 16 * (3 + SETUP + STROBE + HOLD) + GAP, "frame_period", t2 - t1, 186);
    repeat (20) @(negedge i_clk);
    chk(exp_q.size() == 0, "continuous_queue_empty", exp_q.size(), 0);
    for (int r = 0; r < 3; r++) begin
      rand_mem();
      one_frame();
    end
    rand_mem();
    n = fd_cnt;
    push(0, 7);
    i_enable = 1;
    wait_wr(4'b1101, 2'd0);
    i_enable = 0;
    repeat (60) @(negedge i_clk);
    chk(exp_q.size() == 0, "drop_queue_empty", exp_q.size(), 0);
    chk(fd_cnt == n, "drop_no_frame_done", fd_cnt, n);
    chk(o_wr_n == 4'hF, "drop_idle_wr_n", o_wr_n, 15);
    rand_mem();
    push(0, 2);
    i_enable = 1;
    wait_wr(4'b1110, 2'd1);
    #1 i_rst_n = 0;
    i_enable = 0;
    @(negedge i_clk);
    chk_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    chk(exp_q.size() == 0, "reset_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge i_clk);
    one_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hpdl_refresh.md
HPDL_REFRESH -- requirements
Module: hpdl_refresh

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: clocks data/address are stable before the write strobe falls.
REQ-002 Parameter STROBE_CYCLES, default 4: clocks the write strobe is held low.
REQ-003 Parameter HOLD_CYCLES, default 2: clocks data/address are held after the write strobe rises.
REQ-004 Parameter GAP_CYCLES, default 1000: idle clocks between the end of one frame and the start of the next.
REQ-005 Port i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port i_rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Port i_enable, input, 1: high allows refresh frames to run.
REQ-008 Port o_read_enable, input side of the buffer, output, 1: buffer read request.
REQ-009 Port o_read_address, output, 4: buffer position being fetched, 0 to 15.
REQ-010 Port i_read_data, input, 8: buffer character; valid on the clock after o_read_enable.
REQ-011 Port o_data, output, 7: display data bus D6..D0.
REQ-012 Port o_addr, output, 2: display digit select A1..A0.
REQ-013 Port o_wr_n, output, 4: active-low write strobes, one per display.
REQ-014 Port o_frame_done, output, 1: one-clock pulse after position 15 has been written.

Function
REQ-015 The FSM states SHALL be IDLE, FETCH, LATCH, SETUP, STROBE, HOLD, NEXT and GAP.
REQ-016 IDLE: move to FETCH with the index at 0 when i_enable=1.
REQ-017 FETCH: assert o_read_enable for exactly 1 clock with o_read_address equal to the index.
REQ-018 LATCH: register the mapped character from i_read_data; o_read_enable is 0.
REQ-019 SETUP: drive o_data and o_addr for SETUP_CYCLES clocks with o_wr_n=4'hF.
REQ-020 STROBE: drive o_wr_n[index[3:2]]=0 for STROBE_CYCLES clocks; all other strobes stay 1.
REQ-021 HOLD: keep o_data and o_addr stable with o_wr_n=4'hF for HOLD_CYCLES clocks.
REQ-022 NEXT, index<15: increment the index and go to FETCH.
REQ-023 NEXT, index=15: pulse o_frame_done for 1 clock, wrap the index to 0 and go to GAP.
REQ-024 GAP: count GAP_CYCLES, then go to FETCH if i_enable=1, otherwise to IDLE.
REQ-025 o_addr SHALL equal 3 - index[1:0], so buffer position 0 is the leftmost digit of display 0.
REQ-026 Character map, 0x20..0x5F: passed through as the low 7 bits.
REQ-027 Character map, 0x61..0x7A: converted by subtracting 0x20 (lowercase to uppercase).
REQ-028 Character map, any other value: mapped to 0x20 (space).
REQ-029 Only one bit of o_wr_n SHALL ever be low at a time.
REQ-030 o_data and o_addr SHALL never change while any o_wr_n bit is 0.
REQ-031 If i_enable falls mid-character, the current SETUP/STROBE/HOLD sequence SHALL complete; the block then returns to IDLE at NEXT without further fetches or an o_frame_done pulse.
REQ-032 If i_enable falls during GAP, the block SHALL return to IDLE when the count expires.
REQ-033 Each per-state counter SHALL be wide enough for its parameter and reload on state entry; a parameter value of 0 is treated as 1.
REQ-034 Full-frame period = 16*(2+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1)+GAP_CYCLES clocks.

Reset
REQ-035 While i_rst_n=0 at a clock edge: state=IDLE, index=0, counters=0.
REQ-036 Output reset values: o_wr_n=4'hF, o_read_enable=0, o_read_address=0, o_data=7'h20, o_addr=0, o_frame_done=0.
REQ-037 A reset during STROBE SHALL return the strobe high on the same reset edge; the interrupted character is not resumed.

Structure
REQ-038 A shared package hpdl_pkg SHALL hold the FSM state enum, the default timing constants, the display count (4), the digits-per-display count (4) and the blank code 0x20.
REQ-039 The character map SHALL be a separate combinational sub-module, hpdl_char_map (8-bit in, 7-bit out).

Verification
REQ-040 Buffer holds "HELLO WORLD 1234", enable for 1 frame -> 16 strobes; display 0 gets 'H','E','L','L' at o_addr 3,2,1,0; one o_frame_done pulse.
REQ-041 Buffer position 5 = 0x61, position 6 = 0x7F -> o_data is 0x41 at position 5 and 0x20 at position 6.
REQ-042 Defaults (2/4/2) -> each o_wr_n low pulse is exactly 4 clocks, with data stable ≥2 clocks before the fall and ≥2 clocks after the rise.
REQ-043 Drop i_enable during the STROBE of position 7 -> the strobe completes fully, no read at position 8, the block enters IDLE and o_frame_done stays 0.
REQ-044 Assert i_rst_n=0 during a STROBE -> o_wr_n=4'hF on that edge; after release and enable, the first fetch is at address 0.
REQ-045 GAP_CYCLES=10 with continuous enable -> consecutive o_frame_done pulses are exactly 16*11+10=186 clocks apart.
